// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the burst memory responder.
package mem_responder_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 6;
  localparam int LEN_W      = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Host-write, burst-request and read-stream signals of the responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_par;
  logic              busy;

  modport master (
    output we, waddr, wdata, req_valid, req_addr, req_len, rd_ready,
    input  req_ready, rd_valid, rd_data, rd_last, rd_par, busy
  );

  modport slave (
    input  we, waddr, wdata, req_valid, req_addr, req_len, rd_ready,
    output req_ready, rd_valid, rd_data, rd_last, rd_par, busy
  );
endinterface

// File: rtl/mem_responder_ram.sv
// 2**ADDR_W x DATA_W storage: one write port, one registered read port.
// Reads sample the array before the same-edge write lands (read-before-write).
// Optional registered odd parity of the read word under MEM_RESPONDER_PARITY_EN.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int   DATA_W  = DATA_W_DEF,
  parameter int   ADDR_W  = ADDR_W_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
`ifdef MEM_RESPONDER_PARITY_EN
  output logic              rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Read register holds its word unless a new load is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Read register; reset forces the replicated reset bit.
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= {DATA_W{RST_VAL}};
    else     rdata_q <= rdata_d;
  end

  // Array write; reset wins over a coincident write, contents are never cleared.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
  end

  assign rdata = rdata_q;

`ifdef MEM_RESPONDER_PARITY_EN
  logic rpar_d, rpar_q;

  // Parity is loaded alongside the data so both change on the same edge.
  always_comb begin
    rpar_d = rpar_q;
    if (re) rpar_d = ~^mem[raddr];
  end

  // Parity register; reset value matches the parity of the reset word.
  always_ff @(posedge clk) begin
    if (rst) rpar_q <= ~^{DATA_W{RST_VAL}};
    else     rpar_q <= rpar_d;
  end

  assign rpar = rpar_q;
`endif

endmodule

// File: rtl/mem_responder.sv
// Burst read responder over a host-writable RAM.
// Accepts a burst in IDLE, streams one word per accepted beat in STREAM.
// Optional feature macro: MEM_RESPONDER_PARITY_EN (registered odd parity on rd_par).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic RST_VAL = 1'b0,
  parameter int   DATA_W  = DATA_W_DEF,
  parameter int   ADDR_W  = ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  state_t            state_d, state_q;
  logic [LEN_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] ptr_d, ptr_q;
  logic              vld_d, vld_q;
  logic              re;
  logic [ADDR_W-1:0] raddr;

  // Next-state: accept in IDLE, advance on each consumed beat, leave after the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    vld_d   = vld_q;
    re      = 1'b0;
    raddr   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          re      = 1'b1;
          raddr   = bus.req_addr;
          ptr_d   = bus.req_addr;
          cnt_d   = bus.req_len;
          vld_d   = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // Requests arriving here are dropped, not queued.
        if (vld_q && bus.rd_ready) begin
          if (cnt_q != '0) begin
            // Pointer wraps naturally at 2**ADDR_W.
            ptr_d = ptr_q + 1'b1;
            raddr = ptr_q + 1'b1;
            re    = 1'b1;
            cnt_d = cnt_q - 1'b1;
          end else begin
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
    end
  end

  mem_responder_ram #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .RST_VAL (RST_VAL)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.we),
    .waddr (bus.waddr),
    .wdata (bus.wdata),
    .re    (re),
    .raddr (raddr),
`ifdef MEM_RESPONDER_PARITY_EN
    .rpar  (bus.rd_par),
`endif
    .rdata (bus.rd_data)
  );

`ifndef MEM_RESPONDER_PARITY_EN
  assign bus.rd_par = 1'b0;
`endif

  assign bus.rd_valid  = vld_q;
  assign bus.rd_last   = vld_q && (cnt_q == '0);
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == STREAM);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: table of single-word reads plus
// hand-written bursts for wrap, stall, same-cycle write and mid-burst reset.
module tb_mem_responder;
  localparam int DW = 14;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_responder #(.RST_VAL(1'b0), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          par;   // hand-computed ~^data
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_par(input logic [DW-1:0] d);
`ifdef MEM_RESPONDER_PARITY_EN
    return ~^d;
`else
    return 1'b0 & d[0];
`endif
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  // Single-word burst: word appears one cycle after accept, back to IDLE after.
  task automatic rd1(input string name, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic p);
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_len = 3'd0; bus.rd_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
    chk({name, "_data"},  32'(bus.rd_data),  32'(d));
    chk({name, "_last"},  32'(bus.rd_last),  32'd1);
    chk({name, "_par"},   32'(bus.rd_par),   32'(p));
    tick();
    chk({name, "_idle"},  32'({bus.rd_valid, bus.busy, bus.req_ready}), 32'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] w [8];
    logic [DW-1:0] par_rst;

    vecs[0] = '{addr: 6'd5,  data: 14'h1234, par: 1'b0};
    vecs[1] = '{addr: 6'd6,  data: 14'h0001, par: 1'b0};
    vecs[2] = '{addr: 6'd7,  data: 14'h0000, par: 1'b1};
    vecs[3] = '{addr: 6'd30, data: 14'h3FFF, par: 1'b1};
    vecs[4] = '{addr: 6'd31, data: 14'h2AAA, par: 1'b0};
    vecs[5] = '{addr: 6'd63, data: 14'h0007, par: 1'b0};

    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.rd_ready = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    par_rst = '0;
    chk("rst_valid", 32'(bus.rd_valid),  32'd0);
    chk("rst_last",  32'(bus.rd_last),   32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_data",  32'(bus.rd_data),   32'd0);
    chk("rst_par",   32'(bus.rd_par),    32'(exp_par(par_rst)));
    rst = 1'b0;
    tick();

    // Table: write then single-word read
    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].addr, vecs[i].data);
`ifdef MEM_RESPONDER_PARITY_EN
      rd1($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].par);
`else
      rd1($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, 1'b0);
`endif
    end

    // Wrap-around burst 62,63,0,1
    wr(6'd62, 14'h0A0A); wr(6'd63, 14'h0B0B); wr(6'd0, 14'h0C0C); wr(6'd1, 14'h0D0D);
    w[0] = 14'h0A0A; w[1] = 14'h0B0B; w[2] = 14'h0C0C; w[3] = 14'h0D0D;
    bus.req_valid = 1'b1; bus.req_addr = 6'd62; bus.req_len = 3'd3; bus.rd_ready = 1'b1;
    tick();
    // Keep req_valid high: it must be ignored during STREAM.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_v%0d", i), 32'(bus.rd_valid), 32'd1);
      chk($sformatf("wrap_d%0d", i), 32'(bus.rd_data),  32'(w[i]));
      chk($sformatf("wrap_l%0d", i), 32'(bus.rd_last),  32'(i == 3));
      chk($sformatf("wrap_b%0d", i), 32'({bus.busy, bus.req_ready}), 32'b10);
      if (i == 3) bus.req_valid = 1'b0;
      tick();
    end
    chk("wrap_end", 32'({bus.rd_valid, bus.busy, bus.req_ready}), 32'b001);

    // Stall on word 2 with a host write to the held address
    wr(6'd20, 14'h0111); wr(6'd21, 14'h0222); wr(6'd22, 14'h0333);
    bus.req_valid = 1'b1; bus.req_addr = 6'd20; bus.req_len = 3'd2; bus.rd_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("stall_w1", 32'(bus.rd_data), 32'h0111);
    tick();
    chk("stall_w2", 32'(bus.rd_data), 32'h0222);
    bus.rd_ready = 1'b0;
    bus.we = 1'b1; bus.waddr = 6'd21; bus.wdata = 14'h1555;
    tick();
    bus.we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("stall_hold_d%0d", i), 32'(bus.rd_data), 32'h0222);
      chk($sformatf("stall_hold_vl%0d", i), 32'({bus.rd_valid, bus.rd_last}), 32'b10);
      chk($sformatf("stall_hold_p%0d", i), 32'(bus.rd_par), 32'(exp_par(14'h0222)));
      tick();
    end
    chk("stall_hold_d2", 32'(bus.rd_data), 32'h0222);
    bus.rd_ready = 1'b1;
    tick();
    chk("stall_w3",   32'(bus.rd_data), 32'h0333);
    chk("stall_last", 32'(bus.rd_last), 32'd1);
    tick();
    chk("stall_end", 32'(bus.rd_valid), 32'd0);
    rd1("stall_new21", 6'd21, 14'h1555, exp_par(14'h1555));

    // Same-cycle write to the address being advanced to
    wr(6'd8, 14'h0808); wr(6'd9, 14'h0909);
    bus.req_valid = 1'b1; bus.req_addr = 6'd8; bus.req_len = 3'd1; bus.rd_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("rbw_w8", 32'(bus.rd_data), 32'h0808);
    bus.we = 1'b1; bus.waddr = 6'd9; bus.wdata = 14'h3999;
    tick();
    bus.we = 1'b0;
    chk("rbw_old9", 32'(bus.rd_data), 32'h0909);
    chk("rbw_last", 32'(bus.rd_last), 32'd1);
    tick();
    rd1("rbw_new9", 6'd9, 14'h3999, exp_par(14'h3999));

    // Reset on word 2 of an 8-word burst; rst must also block a coincident write
    for (int i = 0; i < 8; i++) begin
      w[i] = 14'(14'h0100 + i * 14'h0011);
      wr(6'(40 + i), w[i]);
    end
    bus.req_valid = 1'b1; bus.req_addr = 6'd40; bus.req_len = 3'd7; bus.rd_ready = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("abort_w1", 32'(bus.rd_data), 32'(w[0]));
    tick();
    chk("abort_w2", 32'(bus.rd_data), 32'(w[1]));
    rst = 1'b1;
    bus.we = 1'b1; bus.waddr = 6'd40; bus.wdata = 14'h3DEA;
    tick();
    rst = 1'b0; bus.we = 1'b0;
    chk("abort_state", 32'({bus.rd_valid, bus.busy, bus.req_ready, bus.rd_last}), 32'b0010);
    chk("abort_data",  32'(bus.rd_data), 32'd0);
    tick(); tick();
    chk("abort_quiet", 32'(bus.rd_valid), 32'd0);
    rd1("abort_mem40", 6'd40, w[0], exp_par(w[0]));
    rd1("abort_mem45", 6'd45, w[5], exp_par(w[5]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
